rob_multi: RTL and testbench
============================

Name: rob_multi

Overview:
- Parametrised successor to the single-issue reorder buffer. Tracks in-flight instructions in program order.
- Accepts results from several CDB ports and retires up to COMMIT_WIDTH instructions per cycle in order.
- Resolves branch mispredicts with a selective tail rollback and a one-cycle flush pulse.
- Gives decode a forwarded operand read and the load buffer wrap-aware memory disambiguation.
- Sits between issue/decode, the CDB arbiter, the register file/commit logic and the load/store units.

Parameters:
- ROB_SIZE, 8, entry count; power of two, at least 4. IX = $clog2(ROB_SIZE).
- COMMIT_WIDTH, 2, maximum non-store retirements per cycle (1..4).
- CDB_PORTS, 2, number of result writeback ports.
- LOAD_PORTS, 3, number of load-buffer disambiguation queries.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; one clock, asynchronous, active-high
- alloc_valid_in  in  1  issue presents an instruction
- alloc_itype_in  in  4  instruction type, codebase iType encoding
- alloc_value_in  in  32  initial value; for BRANCH, bit0 = predicted taken
- alloc_dest_in  in  32  rd index, store base address, or branch alternate PC
- alloc_ready_out  out  1  entry available
- alloc_ix_out  out  IX  index assigned to the allocating instruction (current tail)
- cdb_valid_in  in  CDB_PORTS  per-port result valid
- cdb_ix_in  in  CDB_PORTS x IX  target entry
- cdb_value_in  in  CDB_PORTS x 32  result; for BRANCH, bit0 = actual taken
- cdb_dest_in  in  CDB_PORTS x 32  store address offset
- rd_ix_in  in  2 x IX  decode operand lookup
- rd_value_out  out  2 x 32  operand value
- rd_ready_out  out  2  operand available
- commit_valid_out  out  COMMIT_WIDTH  slot w retiring this cycle
- commit_ix_out / commit_itype_out / commit_value_out / commit_dest_out  out  per-slot IX / 4 / 32 / 32  retiring entry contents
- store_valid_out  out  1  ready STORE at head
- store_read_in  in  1  store unit consumed the head store
- store_addr_out / store_data_out  out  32 / 32  head store address and data
- lb_ix_in  in  LOAD_PORTS x IX  ROB index of each buffered load
- lb_addr_in  in  LOAD_PORTS x 32  load address
- can_load_out  out  LOAD_PORTS  load may proceed
- flush_out  out  1  one-cycle mispredict pulse
- flush_mask_out  out  ROB_SIZE  squashed entries that write a register
- next_pc_out  out  32  redirect PC, valid with flush_out

Behaviour:
- Pointers and occupancy
  - head and tail are IX+1 bits; count = tail - head.
  - Physical index = low IX bits. Age(ix) = (ix - head[IX-1:0]) mod ROB_SIZE.
- Reset (async)
  - head = tail = 0; all ready bits 0; flush_out = 0; flush_mask_out = 0; next_pc_out = 0.
  - Combinational outputs then read: alloc_ready_out = 1, commit_valid_out = 0, store_valid_out = 0, can_load_out = all 1.
  - Reset mid-flush cancels the pulse.
- Allocation
  - alloc_ready_out = (count < ROB_SIZE) && !mispredict_now.
  - On alloc_valid_in && alloc_ready_out: write the entry at tail with ready = 0, then tail++.
  - Full ROB: the allocation is ignored.
- CDB writeback (each port)
  - Ignored unless the entry is occupied (age < count).
  - Non-BRANCH: value <= cdb_value_in; ready <= 1.
  - STORE: additionally dest <= dest + cdb_dest_in.
  - BRANCH: ready <= 1. Mispredict when cdb_value_in[0] != stored value[0].
- Mispredict
  - Several mispredicts in one cycle: the smallest-age branch wins.
  - CDB writes and allocation to entries younger than the winner are dropped that cycle.
  - Next edge: tail <= winner pointer + 1; flush_out = 1 for exactly one cycle; next_pc_out = winner dest.
  - Next edge also sets flush_mask_out bit i for each squashed entry whose iType is OP, OPIMM, LUI, JAL, JALR, LOAD, MUL or DIV.
  - flush_mask_out and next_pc_out return to 0 the cycle after.
- Commit
  - Slot w is valid iff slots 0..w-1 are valid and entry head+w is occupied, ready and not STORE.
  - head advances by the number of valid slots in the same cycle (no backpressure).
  - A BRANCH retires in a slot; the consumer performs no register write for it.
- Store retirement
  - store_valid_out = head entry occupied, ready and STORE; commit slot 0 is then invalid.
  - store_read_in && store_valid_out: head++.
  - store_read_in without store_valid_out is ignored.
- Operand read
  - rd_value_out/rd_ready_out come from the entry.
  - If a CDB port writes that same entry this cycle, forward cdb_value_in with ready = 1 (lowest port wins).
- Disambiguation
  - can_load_out[l] = 0 iff some occupied entry with age < age(lb_ix_in[l]) is a STORE that is either not ready or has dest == lb_addr_in[l].
  - Comparison is wrap-aware.
- Simultaneous events
  - Allocation, commit and CDB in one cycle all take effect.
  - A CDB write and allocation to the same index are impossible by occupancy rules.

Test Plan:
- Reset, then allocate 8 OP entries with no CDB -> 9th alloc_valid_in sees alloc_ready_out = 0; alloc_ix_out = 0..7 in order.
- CDB writes entries 1 then 0 (values 5, 7) -> next cycle both slots commit (ix 0 value 7, ix 1 value 5) and head advances by 2.
- Head = 6, allocate 4 entries (wrap to index 1), STORE at ix 7 not ready, load at ix 1 -> can_load_out = 0. Store resolves to 0x100 and load address is 0x104 -> can_load_out = 1.
- BRANCH at ix 2 predicted 1, actual 0; OP entries at 3 and 4 plus a STORE at 5 -> one flush_out pulse, flush_mask_out = 0x18, next_pc_out = branch dest, tail = 3.
- Same-cycle mispredicts at ix 4 (port 0) and ix 2 (port 1) with head = 1 -> rollback to tail = 3 only.
- CDB writes ix 3 while rd_ix_in[0] = 3 -> rd_ready_out[0] = 1 with the CDB value that same cycle.

Source files
------------

// File: rtl/rob_multi.sv
// Multi-issue reorder buffer: in-order retirement, multi-port CDB writeback,
// selective mispredict rollback, operand forwarding and load disambiguation.
module rob_multi #(
  parameter int ROB_SIZE     = 8,
  parameter int COMMIT_WIDTH = 2,
  parameter int CDB_PORTS    = 2,
  parameter int LOAD_PORTS   = 3,
  localparam int IX          = $clog2(ROB_SIZE)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                alloc_valid_in,
  input  logic [3:0]                          alloc_itype_in,
  input  logic [31:0]                         alloc_value_in,
  input  logic [31:0]                         alloc_dest_in,
  output logic                                alloc_ready_out,
  output logic [IX-1:0]                       alloc_ix_out,
  input  logic [CDB_PORTS-1:0]                cdb_valid_in,
  input  logic [CDB_PORTS-1:0][IX-1:0]        cdb_ix_in,
  input  logic [CDB_PORTS-1:0][31:0]          cdb_value_in,
  input  logic [CDB_PORTS-1:0][31:0]          cdb_dest_in,
  input  logic [1:0][IX-1:0]                  rd_ix_in,
  output logic [1:0][31:0]                    rd_value_out,
  output logic [1:0]                          rd_ready_out,
  output logic [COMMIT_WIDTH-1:0]             commit_valid_out,
  output logic [COMMIT_WIDTH-1:0][IX-1:0]     commit_ix_out,
  output logic [COMMIT_WIDTH-1:0][3:0]        commit_itype_out,
  output logic [COMMIT_WIDTH-1:0][31:0]       commit_value_out,
  output logic [COMMIT_WIDTH-1:0][31:0]       commit_dest_out,
  output logic                                store_valid_out,
  input  logic                                store_read_in,
  output logic [31:0]                         store_addr_out,
  output logic [31:0]                         store_data_out,
  input  logic [LOAD_PORTS-1:0][IX-1:0]       lb_ix_in,
  input  logic [LOAD_PORTS-1:0][31:0]         lb_addr_in,
  output logic [LOAD_PORTS-1:0]               can_load_out,
  output logic                                flush_out,
  output logic [ROB_SIZE-1:0]                 flush_mask_out,
  output logic [31:0]                         next_pc_out
);

  localparam logic [3:0] IT_OP     = 4'd0;
  localparam logic [3:0] IT_OPIMM  = 4'd1;
  localparam logic [3:0] IT_LUI    = 4'd2;
  localparam logic [3:0] IT_JAL    = 4'd4;
  localparam logic [3:0] IT_JALR   = 4'd5;
  localparam logic [3:0] IT_BRANCH = 4'd6;
  localparam logic [3:0] IT_LOAD   = 4'd7;
  localparam logic [3:0] IT_STORE  = 4'd8;
  localparam logic [3:0] IT_MUL    = 4'd9;
  localparam logic [3:0] IT_DIV    = 4'd10;

  typedef logic [IX:0]   ptr_t;
  typedef logic [IX-1:0] idx_t;

  ptr_t                head;
  ptr_t                tail;
  ptr_t                count;
  idx_t                head_ix;
  logic [3:0]          e_itype [ROB_SIZE];
  logic [31:0]         e_value [ROB_SIZE];
  logic [31:0]         e_dest  [ROB_SIZE];
  logic [ROB_SIZE-1:0] e_ready;

  logic                flush_q;
  logic [ROB_SIZE-1:0] mask_q;
  logic [31:0]         npc_q;

  function automatic logic writes_reg(input logic [3:0] t);
    return (t == IT_OP) || (t == IT_OPIMM) || (t == IT_LUI) ||
           (t == IT_JAL) || (t == IT_JALR) || (t == IT_LOAD) ||
           (t == IT_MUL) || (t == IT_DIV);
  endfunction

  function automatic logic occupied(input idx_t age, input ptr_t cnt);
    return {1'b0, age} < cnt;
  endfunction

  assign count   = tail - head;
  assign head_ix = head[IX-1:0];

  logic [CDB_PORTS-1:0] cdb_occ;
  logic [CDB_PORTS-1:0] cdb_mp;
  logic [CDB_PORTS-1:0] cdb_wr;
  idx_t                 cdb_age [CDB_PORTS];
  logic                 win_valid;
  idx_t                 win_age;
  idx_t                 win_ix;

  // Oldest mispredicting branch wins; younger CDB writes are discarded.
  always_comb begin
    win_valid = 1'b0;
    win_age   = '0;
    win_ix    = '0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb_age[p] = cdb_ix_in[p] - head_ix;
      cdb_occ[p] = cdb_valid_in[p] && occupied(cdb_age[p], count);
      cdb_mp[p]  = cdb_occ[p] &&
                   (e_itype[cdb_ix_in[p]] == IT_BRANCH) &&
                   (cdb_value_in[p][0] != e_value[cdb_ix_in[p]][0]);
      if (cdb_mp[p] && (!win_valid || cdb_age[p] < win_age)) begin
        win_valid = 1'b1;
        win_age   = cdb_age[p];
        win_ix    = cdb_ix_in[p];
      end
    end
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb_wr[p] = cdb_occ[p] && !(win_valid && (cdb_age[p] > win_age));
    end
  end

  logic do_alloc;

  assign alloc_ready_out = !count[IX] && !win_valid;
  assign alloc_ix_out    = tail[IX-1:0];
  assign do_alloc        = alloc_valid_in && alloc_ready_out;

  ptr_t ncommit;

  always_comb begin : commit_sel
    logic ok;
    idx_t sx;
    ok      = 1'b1;
    ncommit = '0;
    for (int w = 0; w < COMMIT_WIDTH; w++) begin
      sx = head_ix + idx_t'(w);
      commit_valid_out[w] = ok && (ptr_t'(w) < count) && e_ready[sx] &&
                            (e_itype[sx] != IT_STORE);
      ok = commit_valid_out[w];
      ncommit = ncommit + ptr_t'(commit_valid_out[w]);
      commit_ix_out[w]    = sx;
      commit_itype_out[w] = e_itype[sx];
      commit_value_out[w] = e_value[sx];
      commit_dest_out[w]  = e_dest[sx];
    end
  end

  logic store_pop;

  assign store_valid_out = (count != '0) && e_ready[head_ix] &&
                           (e_itype[head_ix] == IT_STORE);
  assign store_addr_out  = e_dest[head_ix];
  assign store_data_out  = e_value[head_ix];
  assign store_pop       = store_read_in && store_valid_out;

  // Iterate high to low so the lowest matching port has the final say.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rd_value_out[r] = e_value[rd_ix_in[r]];
      rd_ready_out[r] = e_ready[rd_ix_in[r]];
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_wr[p] && (cdb_ix_in[p] == rd_ix_in[r])) begin
          rd_value_out[r] = cdb_value_in[p];
          rd_ready_out[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin : disamb
    idx_t lage;
    idx_t a;
    logic blk;
    for (int l = 0; l < LOAD_PORTS; l++) begin
      lage = lb_ix_in[l] - head_ix;
      blk  = 1'b0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        a = idx_t'(i) - head_ix;
        if (occupied(a, count) && (a < lage) &&
            (e_itype[i] == IT_STORE) &&
            (!e_ready[i] || (e_dest[i] == lb_addr_in[l])))
          blk = 1'b1;
      end
      can_load_out[l] = !blk;
    end
  end

  logic [ROB_SIZE-1:0] sq_mask;

  always_comb begin : squash
    idx_t a;
    for (int i = 0; i < ROB_SIZE; i++) begin
      a = idx_t'(i) - head_ix;
      sq_mask[i] = win_valid && occupied(a, count) && (a > win_age) &&
                   writes_reg(e_itype[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head    <= '0;
      tail    <= '0;
      e_ready <= '0;
      flush_q <= 1'b0;
      mask_q  <= '0;
      npc_q   <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        e_itype[i] <= '0;
        e_value[i] <= '0;
        e_dest[i]  <= '0;
      end
    end else begin
      flush_q <= win_valid;
      mask_q  <= sq_mask;
      npc_q   <= win_valid ? e_dest[win_ix] : 32'd0;
      if (do_alloc) begin
        e_itype[alloc_ix_out] <= alloc_itype_in;
        e_value[alloc_ix_out] <= alloc_value_in;
        e_dest[alloc_ix_out]  <= alloc_dest_in;
        e_ready[alloc_ix_out] <= 1'b0;
      end
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_wr[p]) begin
          if (e_itype[cdb_ix_in[p]] != IT_BRANCH)
            e_value[cdb_ix_in[p]] <= cdb_value_in[p];
          if (e_itype[cdb_ix_in[p]] == IT_STORE)
            e_dest[cdb_ix_in[p]] <= e_dest[cdb_ix_in[p]] + cdb_dest_in[p];
          e_ready[cdb_ix_in[p]] <= 1'b1;
        end
      end
      head <= head + (store_pop ? ptr_t'(1) : ncommit);
      if (win_valid)
        tail <= head + ptr_t'(win_age) + ptr_t'(1);
      else if (do_alloc)
        tail <= tail + ptr_t'(1);
    end
  end

  assign flush_out      = flush_q;
  assign flush_mask_out = mask_q;
  assign next_pc_out    = npc_q;

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: vector table for fill/commit,
// hand sequences for wrap, disambiguation, rollback and forwarding.
module tb_rob_multi;

  localparam logic [3:0] OP  = 4'd0;
  localparam logic [3:0] BR  = 4'd6;
  localparam logic [3:0] LD  = 4'd7;
  localparam logic [3:0] ST  = 4'd8;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             alloc_valid_in;
  logic [3:0]       alloc_itype_in;
  logic [31:0]      alloc_value_in;
  logic [31:0]      alloc_dest_in;
  logic             alloc_ready_out;
  logic [2:0]       alloc_ix_out;
  logic [1:0]       cdb_valid_in;
  logic [1:0][2:0]  cdb_ix_in;
  logic [1:0][31:0] cdb_value_in;
  logic [1:0][31:0] cdb_dest_in;
  logic [1:0][2:0]  rd_ix_in;
  logic [1:0][31:0] rd_value_out;
  logic [1:0]       rd_ready_out;
  logic [1:0]       commit_valid_out;
  logic [1:0][2:0]  commit_ix_out;
  logic [1:0][3:0]  commit_itype_out;
  logic [1:0][31:0] commit_value_out;
  logic [1:0][31:0] commit_dest_out;
  logic             store_valid_out;
  logic             store_read_in;
  logic [31:0]      store_addr_out;
  logic [31:0]      store_data_out;
  logic [2:0][2:0]  lb_ix_in;
  logic [2:0][31:0] lb_addr_in;
  logic [2:0]       can_load_out;
  logic             flush_out;
  logic [7:0]       flush_mask_out;
  logic [31:0]      next_pc_out;

  rob_multi dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .alloc_valid_in(alloc_valid_in), .alloc_itype_in(alloc_itype_in),
    .alloc_value_in(alloc_value_in), .alloc_dest_in(alloc_dest_in),
    .alloc_ready_out(alloc_ready_out), .alloc_ix_out(alloc_ix_out),
    .cdb_valid_in(cdb_valid_in), .cdb_ix_in(cdb_ix_in),
    .cdb_value_in(cdb_value_in), .cdb_dest_in(cdb_dest_in),
    .rd_ix_in(rd_ix_in), .rd_value_out(rd_value_out),
    .rd_ready_out(rd_ready_out),
    .commit_valid_out(commit_valid_out), .commit_ix_out(commit_ix_out),
    .commit_itype_out(commit_itype_out),
    .commit_value_out(commit_value_out),
    .commit_dest_out(commit_dest_out),
    .store_valid_out(store_valid_out), .store_read_in(store_read_in),
    .store_addr_out(store_addr_out), .store_data_out(store_data_out),
    .lb_ix_in(lb_ix_in), .lb_addr_in(lb_addr_in),
    .can_load_out(can_load_out),
    .flush_out(flush_out), .flush_mask_out(flush_mask_out),
    .next_pc_out(next_pc_out)
  );

  always #5 clk_in = ~clk_in;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    alloc_valid_in = 1'b0;
    alloc_itype_in = OP;
    alloc_value_in = '0;
    alloc_dest_in  = '0;
    cdb_valid_in   = '0;
    cdb_ix_in      = '0;
    cdb_value_in   = '0;
    cdb_dest_in    = '0;
    store_read_in  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  task automatic settle();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic alloc(input logic [3:0] it, input logic [31:0] v,
                       input logic [31:0] d);
    alloc_valid_in = 1'b1;
    alloc_itype_in = it;
    alloc_value_in = v;
    alloc_dest_in  = d;
    tick();
  endtask

  task automatic cdb(input int p, input logic [2:0] ix,
                     input logic [31:0] v, input logic [31:0] d);
    cdb_valid_in[p] = 1'b1;
    cdb_ix_in[p]    = ix;
    cdb_value_in[p] = v;
    cdb_dest_in[p]  = d;
  endtask

  typedef struct {
    logic        av;
    logic [1:0]  cv;
    logic [2:0]  cix0;
    logic [31:0] cval0;
    logic        e_ar;
    logic [2:0]  e_aix;
    logic [1:0]  e_cv;
    logic [31:0] e_cval0;
    logic [31:0] e_cval1;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [1:0] cv,
                              input logic [2:0] cix0,
                              input logic [31:0] cval0,
                              input logic e_ar, input logic [2:0] e_aix,
                              input logic [1:0] e_cv,
                              input logic [31:0] e_cval0,
                              input logic [31:0] e_cval1);
    vec_t v;
    v.av = av; v.cv = cv; v.cix0 = cix0; v.cval0 = cval0;
    v.e_ar = e_ar; v.e_aix = e_aix; v.e_cv = e_cv;
    v.e_cval0 = e_cval0; v.e_cval1 = e_cval1;
    return v;
  endfunction

  vec_t vecs [13];

  initial begin
    idle();
    rd_ix_in   = '0;
    lb_ix_in   = '0;
    lb_addr_in = '0;

    for (int k = 0; k < 8; k++)
      vecs[k] = mk(1, 2'b00, 0, 0, 1, 3'(k), 2'b00, 0, 0);
    vecs[8]  = mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    vecs[9]  = mk(0, 2'b01, 1, 5, 0, 0, 2'b00, 0, 0);
    vecs[10] = mk(0, 2'b01, 0, 7, 0, 0, 2'b00, 0, 0);
    vecs[11] = mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 7, 5);
    vecs[12] = mk(0, 2'b00, 0, 0, 1, 0, 2'b00, 0, 0);

    // reset values
    rst_in = 1'b1;
    #3;
    chk("rst_alloc_ready", alloc_ready_out, 1);
    chk("rst_commit", commit_valid_out, 0);
    chk("rst_store", store_valid_out, 0);
    chk("rst_can_load", can_load_out, 3'b111);
    chk("rst_flush", flush_out, 0);
    chk("rst_mask", flush_mask_out, 0);
    chk("rst_npc", next_pc_out, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // fill to full, then out-of-order completion and dual commit
    for (int i = 0; i < 13; i++) begin
      alloc_valid_in = vecs[i].av;
      alloc_itype_in = OP;
      cdb_valid_in   = vecs[i].cv;
      cdb_ix_in[0]   = vecs[i].cix0;
      cdb_value_in[0] = vecs[i].cval0;
      settle();
      chk($sformatf("v%0d_ready", i), alloc_ready_out, vecs[i].e_ar);
      chk($sformatf("v%0d_ix", i), alloc_ix_out, vecs[i].e_aix);
      chk($sformatf("v%0d_commit", i), commit_valid_out, vecs[i].e_cv);
      if (vecs[i].e_cv[0]) begin
        chk($sformatf("v%0d_c0ix", i), commit_ix_out[0], 0);
        chk($sformatf("v%0d_c0val", i), commit_value_out[0], vecs[i].e_cval0);
      end
      if (vecs[i].e_cv[1]) begin
        chk($sformatf("v%0d_c1ix", i), commit_ix_out[1], 1);
        chk($sformatf("v%0d_c1val", i), commit_value_out[1], vecs[i].e_cval1);
      end
      tick();
    end

    // wrap: drain to head = 6
    do_reset();
    for (int k = 0; k < 6; k++) alloc(OP, 0, 0);
    cdb(0, 0, 1, 0); cdb(1, 1, 1, 0); tick();
    cdb(0, 2, 1, 0); cdb(1, 3, 1, 0); tick();
    cdb(0, 4, 1, 0); cdb(1, 5, 1, 0); tick();
    tick();
    settle();
    chk("wrap_tail", alloc_ix_out, 6);
    chk("wrap_empty_commit", commit_valid_out, 0);
    alloc(OP, 0, 0);
    alloc(ST, 0, 32'hF0);
    alloc(OP, 0, 0);
    alloc(LD, 0, 5);
    lb_ix_in[0] = 1; lb_addr_in[0] = 32'h104;
    lb_ix_in[1] = 7; lb_addr_in[1] = 32'h104;
    lb_ix_in[2] = 6; lb_addr_in[2] = 32'h104;
    settle();
    chk("wrap_alloc_ix", alloc_ix_out, 2);
    chk("dis_unready", can_load_out, 3'b110);
    tick();
    cdb(0, 7, 32'hDEAD, 32'h10);
    tick();
    lb_ix_in[1] = 1; lb_addr_in[1] = 32'h100;
    lb_ix_in[2] = 0; lb_addr_in[2] = 32'h200;
    settle();
    chk("dis_resolved", can_load_out, 3'b101);
    chk("st_not_head", store_valid_out, 0);
    tick();
    cdb(0, 6, 1, 0);
    tick();
    settle();
    chk("st_blocks_slot1", commit_valid_out, 2'b01);
    tick();
    settle();
    chk("st_valid", store_valid_out, 1);
    chk("st_addr", store_addr_out, 32'h100);
    chk("st_data", store_data_out, 32'hDEAD);
    chk("st_no_commit", commit_valid_out, 0);
    store_read_in = 1'b1;
    tick();
    settle();
    chk("st_popped", store_valid_out, 0);
    lb_ix_in = '0; lb_addr_in = '0;

    // single mispredict with dropped younger write
    do_reset();
    alloc(OP, 0, 0);
    alloc(OP, 0, 0);
    alloc(BR, 1, 32'h4000);
    alloc(OP, 0, 0);
    alloc(OP, 0, 0);
    alloc(ST, 0, 32'h80);
    cdb(0, 2, 0, 0);
    cdb(1, 4, 32'h55, 0);
    alloc_valid_in = 1'b1;
    settle();
    chk("mp_alloc_block", alloc_ready_out, 0);
    tick();
    rd_ix_in[0] = 2; rd_ix_in[1] = 4;
    settle();
    chk("mp_flush", flush_out, 1);
    chk("mp_mask", flush_mask_out, 8'h18);
    chk("mp_npc", next_pc_out, 32'h4000);
    chk("mp_tail", alloc_ix_out, 3);
    chk("mp_br_ready", rd_ready_out[0], 1);
    chk("mp_drop", rd_ready_out[1], 0);
    tick();
    settle();
    chk("mp_flush_end", flush_out, 0);
    chk("mp_mask_end", flush_mask_out, 0);
    chk("mp_npc_end", next_pc_out, 0);

    // two mispredicts in one cycle, head = 1
    do_reset();
    alloc(OP, 0, 0);
    cdb(0, 0, 3, 0);
    tick();
    settle();
    chk("h1_commit", commit_valid_out, 2'b01);
    tick();
    alloc(OP, 0, 0);
    alloc(BR, 1, 32'h2000);
    alloc(OP, 0, 0);
    alloc(BR, 0, 32'h3000);
    alloc(OP, 0, 0);
    cdb(0, 4, 1, 0);
    cdb(1, 2, 0, 0);
    tick();
    settle();
    chk("mp2_flush", flush_out, 1);
    chk("mp2_npc", next_pc_out, 32'h2000);
    chk("mp2_mask", flush_mask_out, 8'h28);
    chk("mp2_tail", alloc_ix_out, 3);

    // forwarding on the refilled slot
    alloc(OP, 0, 0);
    rd_ix_in[0] = 3; rd_ix_in[1] = 3;
    settle();
    chk("fw_before", rd_ready_out[0], 0);
    cdb(0, 3, 32'h1111, 0);
    cdb(1, 3, 32'hABCD, 0);
    #1;
    chk("fw_ready", rd_ready_out[0], 1);
    chk("fw_value", rd_value_out[0], 32'h1111);
    tick();
    settle();
    chk("fw_stored", rd_value_out[1], 32'h1111);
    chk("fw_stored_rdy", rd_ready_out[1], 1);

    // reset during the flush pulse
    do_reset();
    alloc(BR, 0, 32'h777);
    cdb(0, 0, 1, 0);
    tick();
    settle();
    chk("rf_flush", flush_out, 1);
    chk("rf_npc", next_pc_out, 32'h777);
    rst_in = 1'b1;
    #1;
    chk("rf_cancel", flush_out, 0);
    chk("rf_npc_clr", next_pc_out, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
